wb_regfile_fwd: RTL and testbench
=================================

Name: wb_regfile_fwd

Overview:
- Consumer end of the MEM/WB pipeline register: writeback stage of the 5-stage MIPS pipeline.
- Selects the writeback value and commits it to the 32-entry general register file.
- Serves the two ID-stage read ports.
- Generates EX-stage operand-forwarding selects from the EX/MEM and MEM/WB destinations.
- Keeps a count of committed register writes for debug and perf.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register address width; register count = 2**ADDR_W
CNT_W, 32, width of the committed-write counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
RegWrite  in  1  write enable from MEM/WB (WB bit 0)
MemtoReg  in  1  writeback select from MEM/WB (WB bit 1): 1 = memory data, 0 = ALU result
readDataOut  in  DATA_W  memory read data from MEM/WB
ALUresultOut  in  DATA_W  ALU result from MEM/WB
writeRegOut  in  ADDR_W  destination register from MEM/WB
readReg1  in  ADDR_W  ID read address A (rs)
readReg2  in  ADDR_W  ID read address B (rt)
readData1  out  DATA_W  ID read data A, combinational
readData2  out  DATA_W  ID read data B, combinational
wbData  out  DATA_W  selected writeback value, combinational
exRs  in  ADDR_W  rs of the instruction in EX
exRt  in  ADDR_W  rt of the instruction in EX
memRegWrite  in  1  RegWrite held in EX/MEM
memWriteReg  in  ADDR_W  destination held in EX/MEM
forwardA  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
forwardB  out  2  EX operand B select, same encoding
writeCount  out  CNT_W  number of committed register writes

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high. On a rising clk edge with reset=1, all registers clear to 0 and writeCount clears to 0.
  - A write presented in a reset cycle is discarded.
- Writeback value:
  - wbData = MemtoReg ? readDataOut : ALUresultOut.
  - Purely combinational, zero latency.
- Commit condition:
  - A write commits on a rising clk edge when reset=0, RegWrite=1 and writeRegOut != 0.
  - The destination register then takes wbData.
- Register 0:
  - Hardwired to 0. Reads of address 0 always return 0.
  - Writes to address 0 are dropped and are not counted.
- Read ports:
  - Combinational: readDataN = reg[readRegN].
  - Without the optional feature, a committed write becomes visible to reads on the cycle after the edge.
  - Both ports may read the same address.
- Forwarding (combinational, evaluated independently for exRs→forwardA and exRt→forwardB):
  - 10 if memRegWrite=1, memWriteReg != 0 and memWriteReg == exRx.
  - Else 01 if RegWrite=1, writeRegOut != 0 and writeRegOut == exRx.
  - Else 00.
  - EX/MEM has priority over MEM/WB when both match (most recent producer wins).
  - Encoding 11 is never produced.
- writeCount:
  - Increments by 1 on every committed write.
  - Wraps modulo 2**CNT_W with no saturation and no flag.
- Back-to-back writes to the same register: the last one wins, one per cycle. Each write counts.
- Outputs during reset: combinational outputs keep tracking their inputs. The register file reads 0 from the cycle after reset is sampled.
- X-free: there is no read-before-reset hazard at the outputs once reset has been applied for one cycle.

Optional Feature:
WB_REGFILE_BYPASS_EN
- Defined: a read port returns wbData instead of the stored value when, in the same cycle:
  - RegWrite=1,
  - writeRegOut != 0,
  - readRegN == writeRegOut.
  - This gives write-then-read in the same cycle and removes the third-stage RAW stall.
  - Bypass is suppressed when reset=1; the read then returns the stored value.
- Undefined: reads always return stored contents. The ID stage must stall one extra cycle for a WB→ID dependency.

Test Plan:
1. Reset: reset=1 for 1 cycle → readData1/readData2 = 0 for all 32 addresses, writeCount=0.
2. Writeback select and commit:
   - RegWrite=1, MemtoReg=0, ALUresultOut=0x0000_1234, writeRegOut=8 → wbData=0x1234; after the edge, readReg1=8 gives 0x1234 and writeCount=1.
   - Repeat with MemtoReg=1, readDataOut=0xDEAD_BEEF, writeRegOut=9 → reg 9 = 0xDEADBEEF, writeCount=2.
3. Register 0: RegWrite=1, writeRegOut=0, ALUresultOut=0xFFFF_FFFF → readReg1=0 reads 0; writeCount unchanged.
4. Forwarding priority:
   - exRs=5, memRegWrite=1, memWriteReg=5, RegWrite=1, writeRegOut=5 → forwardA=10.
   - Drop memRegWrite → forwardA=01.
   - exRt=0 with both destinations 0 → forwardB=00.
5. Same-cycle write/read on reg 10 with value 0x55:
   - With WB_REGFILE_BYPASS_EN → readData2=0x55 in the same cycle.
   - Without the macro → old value that cycle, 0x55 the next cycle.
6. Reset mid-operation and counter wrap:
   - Write reg 3 = 7 in the same cycle as reset=1 → reg 3 reads 0 and writeCount=0.
   - With CNT_W=4, 17 commits → writeCount=1.

Source files
------------

// File: rtl/wb_regfile_fwd_if.sv
// MEM/WB writeback, ID read and EX forwarding bus for wb_regfile_fwd.
// master drives the pipeline-side inputs; slave is the register file block.
interface wb_regfile_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              RegWrite;
  logic              MemtoReg;
  logic [DATA_W-1:0] readDataOut;
  logic [DATA_W-1:0] ALUresultOut;
  logic [ADDR_W-1:0] writeRegOut;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] wbData;
  logic [ADDR_W-1:0] exRs;
  logic [ADDR_W-1:0] exRt;
  logic              memRegWrite;
  logic [ADDR_W-1:0] memWriteReg;
  logic [1:0]        forwardA;
  logic [1:0]        forwardB;
  logic [CNT_W-1:0]  writeCount;

  modport master (
    output RegWrite, MemtoReg, readDataOut, ALUresultOut, writeRegOut,
           readReg1, readReg2, exRs, exRt, memRegWrite, memWriteReg,
    input  readData1, readData2, wbData, forwardA, forwardB, writeCount
  );

  modport slave (
    input  RegWrite, MemtoReg, readDataOut, ALUresultOut, writeRegOut,
           readReg1, readReg2, exRs, exRt, memRegWrite, memWriteReg,
    output readData1, readData2, wbData, forwardA, forwardB, writeCount
  );
endinterface

// File: rtl/wb_regfile_fwd.sv
// MIPS writeback stage: 32-entry register file, ID read ports, EX forwarding selects, commit counter.
// Optional same-cycle write->read bypass enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile_fwd_sel #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_ex_reg,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_dst,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_dst,
  output logic [1:0]        o_sel
);
  logic w_mem_hit, w_wb_hit;
  assign w_mem_hit = i_mem_we && (i_mem_dst != '0) && (i_mem_dst == i_ex_reg);
  assign w_wb_hit  = i_wb_we  && (i_wb_dst  != '0) && (i_wb_dst  == i_ex_reg);
  // EX/MEM holds the younger producer, so it wins over MEM/WB
  assign o_sel = w_mem_hit ? 2'b10 : (w_wb_hit ? 2'b01 : 2'b00);
endmodule

module wb_regfile_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_fwd_if.slave bus
);
  localparam int NREG  = 2**ADDR_W;
  localparam int PORTS = 2;

  logic [NREG-1:0][DATA_W-1:0]  r_regs;
  logic [CNT_W-1:0]             r_cnt;
  logic [DATA_W-1:0]            w_wb;
  logic                         w_wr_ok;
  logic                         w_commit;
  logic [PORTS-1:0][ADDR_W-1:0] w_raddr;
  logic [PORTS-1:0][DATA_W-1:0] w_rdata;
  logic [PORTS-1:0][ADDR_W-1:0] w_ex_reg;
  logic [PORTS-1:0][1:0]        w_fwd;

  assign w_wb     = bus.MemtoReg ? bus.readDataOut : bus.ALUresultOut;
  assign w_wr_ok  = bus.RegWrite && (bus.writeRegOut != '0);
  assign w_commit = w_wr_ok && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
      r_cnt  <= '0;
    end else if (w_commit) begin
      r_regs[bus.writeRegOut] <= w_wb;
      r_cnt                   <= r_cnt + CNT_W'(1);
    end
  end

  assign w_raddr  = {bus.readReg2, bus.readReg1};
  assign w_ex_reg = {bus.exRt, bus.exRs};

  for (genvar p = 0; p < PORTS; p++) begin : g_port
`ifdef WB_REGFILE_BYPASS_EN
    assign w_rdata[p] = (w_raddr[p] == '0) ? '0 :
                        (w_commit && (w_raddr[p] == bus.writeRegOut)) ? w_wb :
                        r_regs[w_raddr[p]];
`else
    assign w_rdata[p] = (w_raddr[p] == '0) ? '0 : r_regs[w_raddr[p]];
`endif

    wb_regfile_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd (
      .i_ex_reg  (w_ex_reg[p]),
      .i_mem_we  (bus.memRegWrite),
      .i_mem_dst (bus.memWriteReg),
      .i_wb_we   (bus.RegWrite),
      .i_wb_dst  (bus.writeRegOut),
      .o_sel     (w_fwd[p])
    );
  end

  assign bus.readData1  = w_rdata[0];
  assign bus.readData2  = w_rdata[1];
  assign bus.wbData     = w_wb;
  assign bus.forwardA   = w_fwd[0];
  assign bus.forwardB   = w_fwd[1];
  assign bus.writeCount = r_cnt;
endmodule

// File: tb/tb_wb_regfile_fwd.sv
// Randomized bench for wb_regfile_fwd with an array-based reference model and directed pins.
module tb_wb_regfile_fwd;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        RegWrite, MemtoReg, memRegWrite;
  logic [31:0] readDataOut, ALUresultOut;
  logic [4:0]  writeRegOut, readReg1, readReg2, exRs, exRt, memWriteReg;

  wb_regfile_fwd_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus  ();
  wb_regfile_fwd_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  assign bus.RegWrite = RegWrite;       assign bus4.RegWrite = RegWrite;
  assign bus.MemtoReg = MemtoReg;       assign bus4.MemtoReg = MemtoReg;
  assign bus.readDataOut = readDataOut; assign bus4.readDataOut = readDataOut;
  assign bus.ALUresultOut = ALUresultOut; assign bus4.ALUresultOut = ALUresultOut;
  assign bus.writeRegOut = writeRegOut; assign bus4.writeRegOut = writeRegOut;
  assign bus.readReg1 = readReg1;       assign bus4.readReg1 = readReg1;
  assign bus.readReg2 = readReg2;       assign bus4.readReg2 = readReg2;
  assign bus.exRs = exRs;               assign bus4.exRs = exRs;
  assign bus.exRt = exRt;               assign bus4.exRt = exRt;
  assign bus.memRegWrite = memRegWrite; assign bus4.memRegWrite = memRegWrite;
  assign bus.memWriteReg = memWriteReg; assign bus4.memWriteReg = memWriteReg;

  wb_regfile_fwd #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  wb_regfile_fwd #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // reference state
  logic [31:0] mdl [32];
  int unsigned cnt;
  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wb();
    return MemtoReg ? readDataOut : ALUresultOut;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (!reset && RegWrite && writeRegOut != 5'd0 && a == writeRegOut) return m_wb();
`endif
    return mdl[a];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (memRegWrite && memWriteReg != 5'd0 && memWriteReg == r) return 2'b10;
    if (RegWrite && writeRegOut != 5'd0 && writeRegOut == r) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      cnt = 0;
    end else if (RegWrite && writeRegOut != 5'd0) begin
      mdl[writeRegOut] = m_wb();
      cnt = cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wbData",    bus.wbData,    m_wb());
      chk("readData1", bus.readData1, m_rd(readReg1));
      chk("readData2", bus.readData2, m_rd(readReg2));
      chk("forwardA",  {30'd0, bus.forwardA}, {30'd0, m_fwd(exRs)});
      chk("forwardB",  {30'd0, bus.forwardB}, {30'd0, m_fwd(exRt)});
      chk("writeCount", bus.writeCount, cnt);
      chk("writeCount4", {28'd0, bus4.writeCount}, {28'd0, cnt[3:0]});
      chk("readData1_w4", bus4.readData1, m_rd(readReg1));
    end
  end

  task automatic idle();
    reset = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; memRegWrite = 1'b0;
    readDataOut = '0; ALUresultOut = '0; writeRegOut = '0; memWriteReg = '0;
    readReg1 = '0; readReg2 = '0; exRs = '0; exRt = '0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; MemtoReg = 1'b0; writeRegOut = a; ALUresultOut = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    next();
    idle();
    chk_en = 1'b1;

    // every address reads 0 after reset
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i); readReg2 = 5'(31 - i);
      settle();
      chk("rst_rd1", bus.readData1, 32'd0);
      chk("rst_rd2", bus.readData2, 32'd0);
      next();
    end
    chk("rst_cnt", bus.writeCount, 32'd0);

    // ALU-result writeback
    wr(5'd8, 32'h0000_1234);
    settle();
    chk("wb_alu", bus.wbData, 32'h0000_1234);
    next();
    idle(); readReg1 = 5'd8;
    settle();
    chk("rd_r8", bus.readData1, 32'h0000_1234);
    chk("cnt1",  bus.writeCount, 32'd1);
    next();

    // memory-data writeback
    RegWrite = 1'b1; MemtoReg = 1'b1; readDataOut = 32'hDEAD_BEEF;
    ALUresultOut = 32'h1111_1111; writeRegOut = 5'd9;
    settle();
    chk("wb_mem", bus.wbData, 32'hDEAD_BEEF);
    next();
    idle(); readReg2 = 5'd9;
    settle();
    chk("rd_r9", bus.readData2, 32'hDEAD_BEEF);
    chk("cnt2",  bus.writeCount, 32'd2);
    next();

    // register 0 writes dropped and not counted
    wr(5'd0, 32'hFFFF_FFFF); readReg1 = 5'd0;
    next();
    idle(); readReg1 = 5'd0;
    settle();
    chk("r0_rd",  bus.readData1, 32'd0);
    chk("r0_cnt", bus.writeCount, 32'd2);
    next();

    // forwarding priority
    exRs = 5'd5; memRegWrite = 1'b1; memWriteReg = 5'd5; RegWrite = 1'b1; writeRegOut = 5'd5;
    ALUresultOut = 32'h5;
    exRt = 5'd0;
    settle();
    chk("fwdA_mem", {30'd0, bus.forwardA}, 32'd2);
    chk("fwdB_r0",  {30'd0, bus.forwardB}, 32'd0);
    memRegWrite = 1'b0;
    #1;
    chk("fwdA_wb",  {30'd0, bus.forwardA}, 32'd1);
    memRegWrite = 1'b1; memWriteReg = 5'd0; writeRegOut = 5'd0;
    #1;
    chk("fwdB_zero", {30'd0, bus.forwardB}, 32'd0);
    next();
    idle();

    // same-cycle write/read on reg 10
    wr(5'd10, 32'h55); readReg2 = 5'd10;
    settle();
`ifdef WB_REGFILE_BYPASS_EN
    chk("byp_same", bus.readData2, 32'h55);
`else
    chk("byp_same", bus.readData2, 32'h0);
`endif
    next();
    idle(); readReg2 = 5'd10;
    settle();
    chk("byp_next", bus.readData2, 32'h55);
    next();

    // write during reset is discarded
    reset = 1'b1; wr(5'd3, 32'd7); readReg1 = 5'd3;
    settle();
    chk("rst_no_byp", bus.readData1, 32'd0);
    next();
    idle(); readReg1 = 5'd3;
    settle();
    chk("rst_r3",  bus.readData1, 32'd0);
    chk("rst_cnt2", bus.writeCount, 32'd0);
    next();

    // 17 commits wraps a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      wr(5'(1 + (i % 31)), 32'(i * 3 + 1));
      next();
    end
    idle();
    settle();
    chk("wrap4",   {28'd0, bus4.writeCount}, 32'd1);
    chk("cnt17",   bus.writeCount, 32'd17);
    next();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 79) == 0);
      RegWrite     = $urandom_range(0, 1);
      MemtoReg     = $urandom_range(0, 1);
      readDataOut  = $urandom;
      ALUresultOut = $urandom;
      writeRegOut  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      readReg1     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      readReg2     = ($urandom_range(0, 3) == 0) ? writeRegOut : 5'($urandom);
      exRs         = 5'($urandom_range(0, 7));
      exRt         = 5'($urandom_range(0, 7));
      memRegWrite  = $urandom_range(0, 1);
      memWriteReg  = 5'($urandom_range(0, 7));
      next();
    end
    idle();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
